// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the contact-bounce emulator.
// Holds the FSM state type and the LFSR polynomial / seed defaults.
package bounce_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1 as bit taps 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bounce_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, shifting left every clock.
// A zero seed would lock up, so it is replaced by 1.
module lfsr16
    import bounce_gen_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] state
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
        end else begin
            state <= lfsr_step(state);
        end
    end

endmodule

// File: rtl/bounce_gen.sv
// Emulates a bouncing mechanical contact: a burst of randomly spaced
// toggles, then a stable hold at the target level and a done pulse.
module bounce_gen
    import bounce_gen_pkg::*;
#(
    parameter int          NUM_BOUNCES = 8,
    parameter int          GAP_W       = 4,
    parameter int          SETTLE_CLKS = 100,
    parameter logic [15:0] SEED        = DEFAULT_SEED,
    parameter logic        INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic target_level,
    input  logic abort,
    output logic noisy_out,
    output logic busy,
    output logic done
);

    localparam logic [7:0]  NB      = 8'(NUM_BOUNCES);
    localparam logic [15:0] SC_LAST = 16'(SETTLE_CLKS - 1);

    state_e           state;
    logic             target_q;
    logic [GAP_W:0]   gap_cnt;
    logic [7:0]       bounce_cnt;
    logic [15:0]      settle_cnt;
    logic [15:0]      lfsr;
    logic [GAP_W:0]   gap_load;
    logic             last_toggle;
    logic             lfsr_unused;

    lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .state(lfsr)
    );

    assign gap_load    = {1'b0, lfsr[GAP_W-1:0]} + (GAP_W+1)'(1);
    assign last_toggle = (bounce_cnt == NB - 8'd1);
    assign lfsr_unused = ^lfsr[15:GAP_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            noisy_out  <= INIT_LEVEL;
            busy       <= 1'b0;
            done       <= 1'b0;
            target_q   <= INIT_LEVEL;
            gap_cnt    <= '0;
            bounce_cnt <= '0;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        target_q   <= target_level;
                        gap_cnt    <= gap_load;
                        bounce_cnt <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        state      <= (NB == 8'd0) ? ST_SETTLE : ST_BOUNCE;
                    end
                end
                ST_BOUNCE: begin
                    if (abort) begin
                        noisy_out <= target_q;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end else if (gap_cnt == (GAP_W+1)'(1)) begin
                        bounce_cnt <= bounce_cnt + 8'd1;
                        gap_cnt    <= gap_load;
                        if (last_toggle) begin
                            // final "toggle" lands on the target level
                            noisy_out  <= target_q;
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end else begin
                            noisy_out <= ~noisy_out;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - (GAP_W+1)'(1);
                    end
                end
                ST_SETTLE: begin
                    noisy_out <= target_q;
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (settle_cnt == SC_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt + 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bounce_gen.sv
// Randomized bench for bounce_gen against an event-schedule model.
// Two instances: default parameters and a zero-bounce variant.
module tb_bounce_gen;

    localparam int MAXC = 4096;
    localparam int NBD  = 8;
    localparam int SCD  = 100;
    localparam int SC1  = 30;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] start = '0;
    logic [1:0] tgt = '0;
    logic [1:0] abort = '0;
    logic [1:0] noisy;
    logic [1:0] busy;
    logic [1:0] done;

    bounce_gen u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start[0]),
        .target_level(tgt[0]),
        .abort       (abort[0]),
        .noisy_out   (noisy[0]),
        .busy        (busy[0]),
        .done        (done[0])
    );

    bounce_gen #(
        .NUM_BOUNCES(0),
        .SETTLE_CLKS(SC1)
    ) u_nb0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start[1]),
        .target_level(tgt[1]),
        .abort       (abort[1]),
        .noisy_out   (noisy[1]),
        .busy        (busy[1]),
        .done        (done[1])
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] lv [0:MAXC-1];
    logic        en [0:1][0:MAXC-1];
    logic        eb [0:1][0:MAXC-1];
    logic        ed [0:1][0:MAXC-1];
    logic        cur_t [0:1];
    int          tog_e [0:NBD];

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // polynomial x^16+x^14+x^13+x^11+1, shifted left
    function automatic logic [15:0] lfsr_next(logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    // lv[n] is the LFSR value seen by edge n after reset release
    function automatic void new_epoch();
        lv[0] = 16'hACE1;
        lv[1] = 16'hACE1;
        for (int n = 2; n < MAXC; n++) lv[n] = lfsr_next(lv[n-1]);
        for (int k = 0; k < 2; k++) begin
            cur_t[k] = 1'b0;
            for (int n = 0; n < MAXC; n++) begin
                en[k][n] = 1'b0;
                eb[k][n] = 1'b0;
                ed[k][n] = 1'b0;
            end
        end
    endfunction

    // Build the expected waveform of an event accepted at edge s.
    function automatic void plan(int k, int s, logic t);
        int   nb;
        int   sc;
        int   last;
        int   g;
        int   c;
        logic lvl;
        nb  = (k == 0) ? NBD : 0;
        sc  = (k == 0) ? SCD : SC1;
        lvl = en[k][s-1];
        last = s;
        for (int i = 1; i <= nb; i++) begin
            g = int'(lv[(last < MAXC) ? last : MAXC-1][3:0]) + 1;
            last = last + g;
            tog_e[i] = last;
        end
        for (int n = s; n < MAXC; n++) begin
            eb[k][n] = (n < last + sc);
            ed[k][n] = (n == last + sc);
            if (nb == 0) begin
                en[k][n] = (n == s) ? lvl : t;
            end else begin
                c = 0;
                for (int i = 1; i <= nb; i++) if (tog_e[i] <= n) c++;
                if (c == 0) en[k][n] = lvl;
                else if (c < nb) en[k][n] = lvl ^ c[0];
                else en[k][n] = t;
            end
        end
    endfunction

    function automatic void kill(int k, int a);
        for (int n = a; n < MAXC; n++) begin
            en[k][n] = cur_t[k];
            eb[k][n] = 1'b0;
            ed[k][n] = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) cyc++;
        @(negedge clk);
        if (cyc >= MAXC) begin
            $display("FAIL overrun: cyc %0d limit %0d", cyc, MAXC);
            $fatal(1);
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("noisy%0d", k), 16'(noisy[k]), 16'(en[k][cyc]));
            chk($sformatf("busy%0d", k), 16'(busy[k]), 16'(eb[k][cyc]));
            chk($sformatf("done%0d", k), 16'(done[k]), 16'(ed[k][cyc]));
        end
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    // drive one cycle of inputs on instance k and update the model
    task automatic pulse(int k, logic st, logic t, logic ab);
        int a;
        start[k] = st;
        tgt[k]   = t;
        abort[k] = ab;
        a = cyc + 1;
        if (ab && eb[k][cyc]) begin
            kill(k, a);
        end else if (st && !eb[k][cyc]) begin
            cur_t[k] = t;
            plan(k, a, t);
        end
        tick();
        start[k] = 1'b0;
        abort[k] = 1'b0;
    endtask

    task automatic wait_idle(int k, int budget);
        int i;
        i = 0;
        while (eb[k][cyc] && i < budget) begin
            tick();
            i++;
        end
        chk("idle_budget", 16'(i < budget), 16'd1);
    endtask

    task automatic wait_cyc(int c);
        int i;
        i = 0;
        while (cyc < c && i < 2000) begin
            tick();
            i++;
        end
        chk("reach_cyc", 16'(cyc), 16'(c));
    endtask

    initial begin
        int   s;
        int   mode;
        int   k;
        logic t;
        new_epoch();
        repeat (3) @(negedge clk);
        chk("rst_noisy", 16'(noisy), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_lfsr", u_dut.u_lfsr.state, 16'hACE1);
        rst_n = 1'b1;
        tick();
        chk("lfsr_adv", u_dut.u_lfsr.state, lfsr_next(16'hACE1));

        // full event to level 1, with a stray start at toggle 3
        run($urandom_range(1, 4));
        pulse(0, 1'b1, 1'b1, 1'b0);
        wait_cyc(tog_e[3]);
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 1000);
        run(3);
        chk("final_lvl", 16'(noisy[0]), 16'd1);

        // abort in the 20th bounce cycle, then a normal event
        pulse(0, 1'b1, 1'b1, 1'b0);
        s = cyc;
        wait_cyc(s + 19);
        pulse(0, 1'b0, 1'b0, 1'b1);
        chk("abort_lvl", 16'(noisy[0]), 16'd1);
        chk("abort_busy", 16'(busy[0]), 16'd0);
        run(5);
        pulse(0, 1'b1, 1'b0, 1'b0);
        wait_idle(0, 1000);
        run(2);

        // zero-bounce instance: target 0 from level 0
        pulse(1, 1'b1, 1'b0, 1'b0);
        wait_idle(1, 1000);
        run(3);

        pulse(0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 8; r++) begin
            run($urandom_range(0, 6));
            k    = $urandom_range(0, 1);
            t    = 1'($urandom);
            mode = $urandom_range(0, 2);
            pulse(k, 1'b1, t, (r % 3) == 0);
            if (mode != 0) begin
                s = $urandom_range(1, 120);
                for (int i = 0; i < s && eb[k][cyc]; i++) tick();
                pulse(k, mode == 2, ~t, mode == 1);
            end
            wait_idle(k, 1000);
            run(2);
        end

        // reset in the middle of SETTLE
        pulse(0, 1'b1, 1'b1, 1'b0);
        wait_cyc(tog_e[NBD] + 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_noisy", 16'(noisy[0]), 16'd0);
        chk("mid_rst_busy", 16'(busy[0]), 16'd0);
        chk("mid_rst_done", 16'(done[0]), 16'd0);
        repeat (3) @(negedge clk);
        new_epoch();
        cyc = 0;
        rst_n = 1'b1;
        run(SCD + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter NUM_BOUNCES, default 8, meaning the number of output toggles per event (0..255).
REQ-002 SHALL have parameter GAP_W, default 4, meaning the gap field width; each gap is 1..2^GAP_W clocks.
REQ-003 SHALL have parameter SETTLE_CLKS, default 100, meaning the stable hold cycles before done (1..65535).
REQ-004 SHALL have parameter SEED, default 16'hACE1, meaning the LFSR reset value; 0 is replaced by 16'h0001.
REQ-005 SHALL have parameter INIT_LEVEL, default 1'b0, meaning the noisy_out reset level.
REQ-006 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: request an event, sampled in IDLE only.
REQ-009 SHALL have port target_level, input, 1 bit: final settled level, latched with start.
REQ-010 SHALL have port abort, input, 1 bit: terminate the event and force the target level.
REQ-011 SHALL have port noisy_out, output, 1 bit: emulated bouncing contact signal, registered.
REQ-012 SHALL have port busy, output, 1 bit: high from the cycle after accepted start until the return to IDLE.
REQ-013 SHALL have port done, output, 1 bit: single-cycle pulse at event completion.

Function
REQ-014 SHALL implement an FSM with states IDLE, BOUNCE and SETTLE.
REQ-015 SHALL run a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, shift left) that advances every clock in all states.
REQ-016 SHALL, in IDLE with start=1, latch target_level into target_q, load gap_cnt with lfsr[GAP_W-1:0]+1, clear bounce_cnt and go to BOUNCE; if NUM_BOUNCES=0, it SHALL go to SETTLE instead.
REQ-017 SHALL, in BOUNCE, decrement gap_cnt each cycle; at gap_cnt=1 it SHALL toggle noisy_out on that edge, increment bounce_cnt and reload gap_cnt from the current LFSR.
REQ-018 SHALL, when the NUM_BOUNCES-th toggle occurs, go to SETTLE with noisy_out driven to target_q on that same edge.
REQ-019 SHALL, in SETTLE, hold noisy_out at target_q and count SETTLE_CLKS cycles, then pulse done for 1 cycle and return to IDLE.
REQ-020 SHALL have busy=1 exactly while in BOUNCE or SETTLE, and done=1 only on the cycle after the last SETTLE cycle (with busy=0).
REQ-021 SHALL ignore start while busy, with no re-latch of target_level.
REQ-022 SHALL, on abort=1 in BOUNCE or SETTLE, drive noisy_out to target_q at the next edge, go to IDLE, and assert no done; abort SHALL have priority over toggle/settle completion in the same cycle.
REQ-023 SHALL take no action on abort in IDLE; on simultaneous start and abort in IDLE, start SHALL win.
REQ-024 SHALL keep noisy_out unchanged in IDLE, at the last level.
REQ-025 SHALL size gap_cnt at GAP_W+1 bits, bounce_cnt at 8 bits and settle_cnt at 16 bits, with no wrap within a legal event.

Reset
REQ-026 SHALL asynchronously set, on rst_n=0: state=IDLE, noisy_out=INIT_LEVEL, busy=0, done=0, counters=0, target_q=INIT_LEVEL, lfsr=SEED (or 1 if SEED=0).
REQ-027 SHALL treat reset mid-event as an abort-to-INIT_LEVEL, with no done.
REQ-028 SHALL have reset deassertion synchronized externally; the first LFSR advance occurs on the first clock with rst_n=1.

Structure
REQ-029 SHALL place the state enum, LFSR tap constant and default seed in shared package bounce_gen_pkg.
REQ-030 SHALL implement the LFSR as sub-module lfsr16 (clk, rst_n, seed parameter, 16-bit state out).
REQ-031 SHALL be implementable in 120-400 lines of RTL, with no latches and all outputs registered.

Verification
REQ-032 Reset: hold rst_n=0 -> noisy_out=0, busy=0, done=0, LFSR=16'hACE1 on first active clock.
REQ-033 Defaults, start with target_level=1 from 0 -> exactly 8 toggles then 1, each gap 1..16 matching the bench LFSR model, 100 stable cycles, done single pulse.
REQ-034 start pulsed again at toggle 3 with target_level=0 -> ignored; final level 1, toggle count 8.
REQ-035 abort at cycle 20 of BOUNCE, target 1 -> noisy_out=1 next cycle, busy=0, done never asserted; next start accepted normally.
REQ-036 NUM_BOUNCES=0, start with target 0 at level 0 -> no edges, busy for exactly SETTLE_CLKS cycles, then done.
REQ-037 rst_n asserted mid-SETTLE -> immediate noisy_out=INIT_LEVEL, FSM IDLE, no done pulse after release.
